// File: rtl/comperator_lite_pkg.sv
// rtl/comperator_lite_pkg.sv - shared constants and helpers for the comperator lite register block
package comperator_lite_pkg;

  localparam int NUM_REGS = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [4:0] REG_CTRL_OFS = 5'h00;
  localparam logic [4:0] REG_CFG0_OFS = 5'h04;
  localparam logic [4:0] REG_CFG1_OFS = 5'h08;
  localparam logic [4:0] REG_CFG2_OFS = 5'h0C;

  // Map a decode error flag onto the bus response code.
  function automatic logic [1:0] resp_for(input logic err);
    return err ? RESP_SLVERR : RESP_OKAY;
  endfunction

endpackage

// File: rtl/comperator_lite_regs_slave_if.sv
// rtl/comperator_lite_regs_slave_if.sv - AXI4-Lite bus bundle with master/slave views
interface comperator_lite_regs_slave_if #(
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int C_S_AXI_DATA_WIDTH = 32
);
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic [2:0]                      S_AXI_AWPROT;
  logic                            S_AXI_AWVALID;
  logic                            S_AXI_AWREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                            S_AXI_WVALID;
  logic                            S_AXI_WREADY;
  logic [1:0]                      S_AXI_BRESP;
  logic                            S_AXI_BVALID;
  logic                            S_AXI_BREADY;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic [2:0]                      S_AXI_ARPROT;
  logic                            S_AXI_ARVALID;
  logic                            S_AXI_ARREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]                      S_AXI_RRESP;
  logic                            S_AXI_RVALID;
  logic                            S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

endinterface

// File: rtl/comperator_lite_strb_merge.sv
// rtl/comperator_lite_strb_merge.sv - byte-strobe merge of new write data into an old register value
module comperator_lite_strb_merge #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   old_data,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  output logic [DATA_WIDTH-1:0]   merged
);

  // Take each byte from wdata where its strobe is set, otherwise keep the old byte.
  always_comb begin
    merged = old_data;
    for (int b = 0; b < DATA_WIDTH/8; b++) begin
      if (wstrb[b]) merged[b*8 +: 8] = wdata[b*8 +: 8];
    end
  end

endmodule

// File: rtl/comperator_lite_regs_slave.sv
// rtl/comperator_lite_regs_slave.sv - AXI4-Lite register file for the comperator core (optional COMPERATOR_LITE_ADDR_ERR_EN)
module comperator_lite_regs_slave
  import comperator_lite_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                                   ACLK,
  input  logic                                   ARESETN,
  comperator_lite_regs_slave_if.slave            s_axi,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] cfg_regs
);

  localparam int DW     = C_S_AXI_DATA_WIDTH;
  localparam int AW     = C_S_AXI_ADDR_WIDTH;
  localparam int STRB_W = DW/8;

  // Readies stay low until the first edge after reset release.
  logic                        started;

  logic                        aw_held;
  logic [AW-1:0]               aw_addr_q;
  logic                        w_held;
  logic [DW-1:0]               w_data_q;
  logic [STRB_W-1:0]           w_strb_q;
  logic                        bvalid_q;
  logic [1:0]                  bresp_q;

  logic                        rvalid_q;
  logic [DW-1:0]               rdata_q;
  logic [1:0]                  rresp_q;

  logic [NUM_REGS-1:0][DW-1:0] regs;

  logic [1:0]                  wr_idx;
  logic                        wr_err;
  logic [1:0]                  rd_idx;
  logic                        rd_err;
  logic [DW-1:0]               merged;
  logic                        unused_bits;

  logic aw_hs, w_hs, ar_hs, commit;

  assign s_axi.S_AXI_AWREADY = started && !aw_held && !bvalid_q;
  assign s_axi.S_AXI_WREADY  = started && !w_held && !bvalid_q;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_ARREADY = started && !rvalid_q;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;

  assign aw_hs  = s_axi.S_AXI_AWVALID && s_axi.S_AXI_AWREADY;
  assign w_hs   = s_axi.S_AXI_WVALID  && s_axi.S_AXI_WREADY;
  assign ar_hs  = s_axi.S_AXI_ARVALID && s_axi.S_AXI_ARREADY;
  assign commit = aw_held && w_held;

  assign cfg_regs = regs;

`ifdef COMPERATOR_LITE_ADDR_ERR_EN
  localparam int IDX_W = AW - 2;
  logic [IDX_W-1:0] wr_full_idx;
  logic [IDX_W-1:0] rd_full_idx;

  // Decode the full word index so that holes above the register file can be flagged.
  always_comb begin
    wr_full_idx = aw_addr_q[AW-1:2];
    rd_full_idx = s_axi.S_AXI_ARADDR[AW-1:2];
    wr_err      = (wr_full_idx >= IDX_W'(NUM_REGS));
    rd_err      = (rd_full_idx >= IDX_W'(NUM_REGS));
    wr_idx      = wr_full_idx[1:0];
    rd_idx      = rd_full_idx[1:0];
  end

  assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                         aw_addr_q[1:0], s_axi.S_AXI_ARADDR[1:0]};
`else
  // Only the low word index bits select a register, so addresses alias every 16 bytes.
  always_comb begin
    wr_idx = aw_addr_q[3:2];
    rd_idx = s_axi.S_AXI_ARADDR[3:2];
    wr_err = 1'b0;
    rd_err = 1'b0;
  end

  assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                         aw_addr_q[1:0], s_axi.S_AXI_ARADDR[1:0],
                         aw_addr_q[AW-1:4], s_axi.S_AXI_ARADDR[AW-1:4]};
`endif

  comperator_lite_strb_merge #(
    .DATA_WIDTH (DW)
  ) u_strb_merge (
    .old_data (regs[wr_idx]),
    .wdata    (w_data_q),
    .wstrb    (w_strb_q),
    .merged   (merged)
  );

  // Write channel: latch AW and W independently, commit once both are held, then hold B until taken.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      started   <= 1'b0;
      aw_held   <= 1'b0;
      aw_addr_q <= '0;
      w_held    <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      regs      <= '0;
    end else begin
      started <= 1'b1;
      if (aw_hs) begin
        aw_held   <= 1'b1;
        aw_addr_q <= s_axi.S_AXI_AWADDR;
      end
      if (w_hs) begin
        w_held   <= 1'b1;
        w_data_q <= s_axi.S_AXI_WDATA;
        w_strb_q <= s_axi.S_AXI_WSTRB;
      end
      if (commit) begin
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
        bvalid_q <= 1'b1;
        bresp_q  <= resp_for(wr_err);
        if (!wr_err) regs[wr_idx] <= merged;
      end else if (bvalid_q && s_axi.S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  // Read channel: capture the pre-commit register value on AR handshake and hold until taken.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_err ? '0 : regs[rd_idx];
      rresp_q  <= resp_for(rd_err);
    end else if (rvalid_q && s_axi.S_AXI_RREADY) begin
      rvalid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_comperator_lite_regs_slave.sv
// tb/tb_comperator_lite_regs_slave.sv - directed self-checking bench for comperator_lite_regs_slave
module tb_comperator_lite_regs_slave;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] cfg_regs;

  int n_checks = 0;
  int n_fail   = 0;

  comperator_lite_regs_slave_if #(.C_S_AXI_ADDR_WIDTH(5), .C_S_AXI_DATA_WIDTH(32)) bus ();

  comperator_lite_regs_slave #(
    .C_S_AXI_DATA_WIDTH (32),
    .C_S_AXI_ADDR_WIDTH (5)
  ) dut (
    .ACLK     (clk),
    .ARESETN  (rst_n),
    .s_axi    (bus),
    .cfg_regs (cfg_regs)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // All bus tasks are entered and left on a falling edge.
  task automatic send_aw(input logic [4:0] addr);
    logic hs;
    int n;
    bus.S_AXI_AWADDR  = addr;
    bus.S_AXI_AWVALID = 1'b1;
    hs = 1'b0;
    n  = 0;
    while (!hs && n < 64) begin
      hs = bus.S_AXI_AWREADY;
      @(negedge clk);
      n++;
    end
    bus.S_AXI_AWVALID = 1'b0;
    if (!hs) check_eq("aw_timeout", 0, 1);
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb);
    logic hs;
    int n;
    bus.S_AXI_WDATA  = data;
    bus.S_AXI_WSTRB  = strb;
    bus.S_AXI_WVALID = 1'b1;
    hs = 1'b0;
    n  = 0;
    while (!hs && n < 64) begin
      hs = bus.S_AXI_WREADY;
      @(negedge clk);
      n++;
    end
    bus.S_AXI_WVALID = 1'b0;
    if (!hs) check_eq("w_timeout", 0, 1);
  endtask

  task automatic wait_b(output logic [1:0] resp);
    int n;
    n = 0;
    while (!bus.S_AXI_BVALID && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!bus.S_AXI_BVALID) begin
      check_eq("b_timeout", 0, 1);
      resp = 2'b11;
    end else begin
      resp = bus.S_AXI_BRESP;
      bus.S_AXI_BREADY = 1'b1;
      @(negedge clk);
      bus.S_AXI_BREADY = 1'b0;
    end
  endtask

  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    logic aw_done, w_done, aw_hs, w_hs;
    int n;
    bus.S_AXI_AWADDR  = addr;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WDATA   = data;
    bus.S_AXI_WSTRB   = strb;
    bus.S_AXI_WVALID  = 1'b1;
    bus.S_AXI_BREADY  = 1'b1;
    aw_done = 1'b0;
    w_done  = 1'b0;
    n = 0;
    while (!(aw_done && w_done) && n < 64) begin
      aw_hs = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
      w_hs  = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
      @(negedge clk);
      n++;
      if (aw_hs) begin bus.S_AXI_AWVALID = 1'b0; aw_done = 1'b1; end
      if (w_hs)  begin bus.S_AXI_WVALID  = 1'b0; w_done  = 1'b1; end
    end
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    if (!(aw_done && w_done)) check_eq("wr_addr_timeout", 0, 1);
    wait_b(resp);
  endtask

  task automatic axi_read(input logic [4:0] addr, output logic [31:0] data, output logic [1:0] resp);
    logic hs;
    int n;
    bus.S_AXI_ARADDR  = addr;
    bus.S_AXI_ARVALID = 1'b1;
    bus.S_AXI_RREADY  = 1'b1;
    hs = 1'b0;
    n  = 0;
    while (!hs && n < 64) begin
      hs = bus.S_AXI_ARREADY;
      @(negedge clk);
      n++;
    end
    bus.S_AXI_ARVALID = 1'b0;
    n = 0;
    while (!bus.S_AXI_RVALID && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!hs || !bus.S_AXI_RVALID) begin
      check_eq("rd_timeout", 0, 1);
      data = '0;
      resp = 2'b11;
    end else begin
      data = bus.S_AXI_RDATA;
      resp = bus.S_AXI_RRESP;
    end
    @(negedge clk);
    bus.S_AXI_RREADY = 1'b0;
  endtask

  // One channel presented first, the other only after a gap; no response may appear early.
  task automatic split_write(input logic [4:0] addr, input logic [31:0] data,
                             input logic w_first, output logic [1:0] resp);
    if (w_first) send_w(data, 4'hF);
    else         send_aw(addr);
    for (int i = 0; i < 3; i++) begin
      check_eq(w_first ? "early_bvalid_wfirst" : "early_bvalid_awfirst", bus.S_AXI_BVALID, 0);
      @(negedge clk);
    end
    if (w_first) send_aw(addr);
    else         send_w(data, 4'hF);
    wait_b(resp);
  endtask

  logic [31:0] wr_tbl [4] = '{32'h0101FFFF, 32'habcd0001, 32'hdead0011, 32'hbeef0011};
  logic [31:0] rdata;
  logic [1:0]  resp;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bus.S_AXI_AWADDR  = '0;
    bus.S_AXI_AWPROT  = '0;
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA   = '0;
    bus.S_AXI_WSTRB   = '0;
    bus.S_AXI_WVALID  = 1'b0;
    bus.S_AXI_BREADY  = 1'b0;
    bus.S_AXI_ARADDR  = '0;
    bus.S_AXI_ARPROT  = '0;
    bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY  = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_awready", bus.S_AXI_AWREADY, 0);
    check_eq("rst_wready",  bus.S_AXI_WREADY, 0);
    check_eq("rst_arready", bus.S_AXI_ARREADY, 0);
    check_eq("rst_bvalid",  bus.S_AXI_BVALID, 0);
    check_eq("rst_rvalid",  bus.S_AXI_RVALID, 0);
    check_eq("rst_cfg",     cfg_regs, 128'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_awready", bus.S_AXI_AWREADY, 1);
    check_eq("post_rst_wready",  bus.S_AXI_WREADY, 1);
    check_eq("post_rst_arready", bus.S_AXI_ARREADY, 1);

    // Sequential write/read of all four registers
    for (int i = 0; i < 4; i++) begin
      axi_write(5'(i*4), wr_tbl[i], 4'hF, resp);
      check_eq("seq_bresp", resp, 0);
      axi_read(5'(i*4), rdata, resp);
      check_eq("seq_rresp", resp, 0);
      check_eq("seq_rdata", rdata, wr_tbl[i]);
    end
    check_eq("seq_cfg", cfg_regs, {32'hbeef0011, 32'hdead0011, 32'habcd0001, 32'h0101FFFF});

    // Channel ordering: W first, then AW first
    split_write(5'h04, 32'h12345678, 1'b1, resp);
    check_eq("wfirst_bresp", resp, 0);
    check_eq("wfirst_reg1", cfg_regs[63:32], 32'h12345678);
    axi_write(5'h04, 32'habcd0001, 4'hF, resp);
    check_eq("restore_reg1", cfg_regs[63:32], 32'habcd0001);
    split_write(5'h04, 32'h12345678, 1'b0, resp);
    check_eq("awfirst_bresp", resp, 0);
    check_eq("awfirst_reg1", cfg_regs[63:32], 32'h12345678);

    // Partial strobe with commit latency and B backpressure
    bus.S_AXI_AWADDR  = 5'h08;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WDATA   = 32'hFFFFFFFF;
    bus.S_AXI_WSTRB   = 4'b0101;
    bus.S_AXI_WVALID  = 1'b1;
    bus.S_AXI_BREADY  = 1'b0;
    @(negedge clk);
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    check_eq("lat_bvalid_n1", bus.S_AXI_BVALID, 0);
    check_eq("lat_reg2_n1", cfg_regs[95:64], 32'hdead0011);
    @(negedge clk);
    check_eq("strb_reg2", cfg_regs[95:64], 32'hdeFF00FF);
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_bvalid",  bus.S_AXI_BVALID, 1);
      check_eq("bp_bresp",   bus.S_AXI_BRESP, 0);
      check_eq("bp_awready", bus.S_AXI_AWREADY, 0);
      check_eq("bp_wready",  bus.S_AXI_WREADY, 0);
      @(negedge clk);
    end
    bus.S_AXI_BREADY = 1'b1;
    @(negedge clk);
    bus.S_AXI_BREADY = 1'b0;
    check_eq("bp_bvalid_done", bus.S_AXI_BVALID, 0);
    check_eq("bp_awready_back", bus.S_AXI_AWREADY, 1);

    // R backpressure
    bus.S_AXI_ARADDR  = 5'h08;
    bus.S_AXI_ARVALID = 1'b1;
    bus.S_AXI_RREADY  = 1'b0;
    check_eq("rbp_arready_pre", bus.S_AXI_ARREADY, 1);
    @(negedge clk);
    bus.S_AXI_ARVALID = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_eq("rbp_rvalid",  bus.S_AXI_RVALID, 1);
      check_eq("rbp_rdata",   bus.S_AXI_RDATA, 32'hdeFF00FF);
      check_eq("rbp_rresp",   bus.S_AXI_RRESP, 0);
      check_eq("rbp_arready", bus.S_AXI_ARREADY, 0);
      @(negedge clk);
    end
    bus.S_AXI_RREADY = 1'b1;
    @(negedge clk);
    bus.S_AXI_RREADY = 1'b0;
    check_eq("rbp_rvalid_done", bus.S_AXI_RVALID, 0);
    check_eq("rbp_arready_back", bus.S_AXI_ARREADY, 1);

    // Same-edge read and write commit on register 0
    bus.S_AXI_AWADDR  = 5'h00;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WDATA   = 32'hCAFEF00D;
    bus.S_AXI_WSTRB   = 4'hF;
    bus.S_AXI_WVALID  = 1'b1;
    @(negedge clk);
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    bus.S_AXI_ARADDR  = 5'h00;
    bus.S_AXI_ARVALID = 1'b1;
    @(negedge clk);
    bus.S_AXI_ARVALID = 1'b0;
    check_eq("coll_rvalid", bus.S_AXI_RVALID, 1);
    check_eq("coll_rdata_old", bus.S_AXI_RDATA, 32'h0101FFFF);
    check_eq("coll_bvalid", bus.S_AXI_BVALID, 1);
    check_eq("coll_reg0_new", cfg_regs[31:0], 32'hCAFEF00D);
    bus.S_AXI_BREADY = 1'b1;
    bus.S_AXI_RREADY = 1'b1;
    @(negedge clk);
    bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_RREADY = 1'b0;
    axi_read(5'h00, rdata, resp);
    check_eq("coll_rdata_later", rdata, 32'hCAFEF00D);

    // Zero strobe: no change, OKAY
    axi_write(5'h00, 32'hFFFFFFFF, 4'h0, resp);
    check_eq("strb0_bresp", resp, 0);
    check_eq("strb0_reg0", cfg_regs[31:0], 32'hCAFEF00D);

    // Reset while a write response is pending
    bus.S_AXI_AWADDR  = 5'h0C;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WDATA   = 32'h00000055;
    bus.S_AXI_WVALID  = 1'b1;
    @(negedge clk);
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_pre_bvalid", bus.S_AXI_BVALID, 1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_bvalid", bus.S_AXI_BVALID, 0);
    check_eq("mid_rst_cfg", cfg_regs, 128'h0);
    check_eq("mid_rst_awready", bus.S_AXI_AWREADY, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_awready_back", bus.S_AXI_AWREADY, 1);

    // Address decode beyond the register file
    axi_write(5'h00, 32'hA5A5A5A5, 4'hF, resp);
    check_eq("dec_base_reg0", cfg_regs[31:0], 32'hA5A5A5A5);
`ifdef COMPERATOR_LITE_ADDR_ERR_EN
    axi_write(5'h10, 32'h11112222, 4'hF, resp);
    check_eq("oor_bresp", resp, 2'b10);
    check_eq("oor_cfg", cfg_regs, {96'h0, 32'hA5A5A5A5});
    axi_read(5'h10, rdata, resp);
    check_eq("oor_rdata", rdata, 32'h0);
    check_eq("oor_rresp", resp, 2'b10);
`else
    axi_write(5'h14, 32'h11112222, 4'hF, resp);
    check_eq("alias_bresp", resp, 0);
    check_eq("alias_cfg", cfg_regs, {64'h0, 32'h11112222, 32'hA5A5A5A5});
    axi_read(5'h10, rdata, resp);
    check_eq("alias_rdata", rdata, 32'hA5A5A5A5);
    check_eq("alias_rresp", resp, 0);
    axi_read(5'h07, rdata, resp);
    check_eq("lowbits_rdata", rdata, 32'h11112222);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/comperator_lite_regs_slave.md
Name: comperator_lite_regs_slave

Overview:
- AXI4-Lite slave (responder) register file for the comperator IP.
- Four 32-bit read/write configuration registers at byte offsets 0x0, 0x4, 0x8 and 0xC.
- Driven by the system AXI4-Lite master; register contents are exported in parallel to the comparator core.
- Independent write and read channels, single outstanding transaction per channel, byte-strobe writes.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 5, byte address width; word index = addr[4:2].
- NUM_REGS, 4, number of implemented registers; fixed at 4.

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  asynchronous active-low reset
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
- S_AXI_AWPROT  in  3  ignored
- S_AXI_AWVALID  in  1  write address valid
- S_AXI_AWREADY  out  1  write address ready
- S_AXI_WDATA  in  32  write data
- S_AXI_WSTRB  in  4  byte strobes
- S_AXI_WVALID  in  1  write data valid
- S_AXI_WREADY  out  1  write data ready
- S_AXI_BRESP  out  2  write response
- S_AXI_BVALID  out  1  write response valid
- S_AXI_BREADY  in  1  write response ready
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
- S_AXI_ARPROT  in  3  ignored
- S_AXI_ARVALID  in  1  read address valid
- S_AXI_ARREADY  out  1  read address ready
- S_AXI_RDATA  out  32  read data
- S_AXI_RRESP  out  2  read response
- S_AXI_RVALID  out  1  read data valid
- S_AXI_RREADY  in  1  read data ready
- cfg_regs  out  128  {reg3,reg2,reg1,reg0}, registered

Behaviour:
- Reset (ARESETN low, asynchronous):
  - All registers, held flags and outputs go to 0, including READY signals.
  - A reset mid-transaction drops any outstanding B/R response; no partial write occurs.
  - READY signals rise on the first clock edge after deassertion.
- Write channel:
  - AWREADY = !aw_held && !BVALID; WREADY = !w_held && !BVALID.
  - AW and W are accepted independently and in either order; each is latched into a holding register with its held flag set.
  - Commit edge (aw_held && w_held): for each byte b with WSTRB[b]=1, reg[idx] byte b is updated; both held flags clear; BVALID is set to 1 with BRESP.
  - Latency when AW and W handshake in the same cycle N: held in N+1; register and cfg_regs updated and BVALID high in N+2.
  - BVALID and BRESP stay stable until BREADY; readies reassert the cycle after the B handshake.
  - WSTRB=0: no register change, OKAY response still returned.
- Read channel:
  - ARREADY = !RVALID.
  - On AR handshake at edge E, RDATA is captured from the register value before any write commit at E, and RVALID rises at E.
  - A same-edge read and write to the same register returns the old value.
  - RVALID, RDATA and RRESP are held until RREADY; ARREADY reasserts the cycle after the R handshake.
- Address decode:
  - addr[1:0] ignored.
  - Without the optional feature, idx = addr[3:2]; addresses wrap modulo 16 bytes.
- Responses: OKAY (2'b00) unless the optional feature flags an error.
- Channel independence: read and write channels never stall each other.

Optional Feature:
- Macro: COMPERATOR_LITE_ADDR_ERR_EN.
- Defined:
  - Full index addr[C_S_AXI_ADDR_WIDTH-1:2] is decoded; index >= NUM_REGS is out of range.
  - Out-of-range write: no register change, BRESP=SLVERR (2'b10).
  - Out-of-range read: RDATA=0, RRESP=SLVERR.
- Undefined: addresses alias modulo 16 bytes; the response is always OKAY.

Decomposition:
- Package comperator_lite_pkg:
  - RESP_OKAY, RESP_SLVERR
  - NUM_REGS
  - Register offset constants REG_CTRL_OFS=0x0, REG_CFG0_OFS=0x4, REG_CFG1_OFS=0x8, REG_CFG2_OFS=0xC
- One natural sub-module, comperator_lite_strb_merge: combinational byte-strobe merge of old value, WDATA and WSTRB. It is reused by later register blocks.

Test Plan:
- Sequential write/read loop at 0x0, 0x4, 0x8, 0xC with data 0x0101FFFF, 0xabcd0001, 0xdead0011, 0xbeef0011, all WSTRB=4'hF.
  - Every BRESP and RRESP = 0.
  - Each readback matches its write; cfg_regs = {beef0011, dead0011, abcd0001, 0101FFFF}.
- Channel ordering at 0x4 (reg1 = 0xabcd0001 beforehand):
  - W presented 3 cycles before AW with data 0x12345678 → no BVALID until AW is accepted; reg1 = 0x12345678.
  - Repeat with AW presented first → same result.
- Partial strobe: reg2 = 0xdead0011, write 0xFFFFFFFF to 0x8 with WSTRB=4'b0101 → reg2 = 0xdeFF00FF.
- Backpressure:
  - BREADY held low for 5 cycles → BVALID/BRESP stable and AWREADY=WREADY=0 throughout.
  - RREADY held low → RDATA stable and ARREADY=0.
- Same-edge collision: read and write of 0x0 handshake on the same edge, old value 0x0101FFFF, new value 0xCAFEF00D.
  - RDATA = 0x0101FFFF; a later read returns 0xCAFEF00D.
- Mid-transaction reset: reset asserted while BVALID=1 → BVALID=0 and cfg_regs=0 immediately.
- COMPERATOR_LITE_ADDR_ERR_EN defined: write to 0x10 → SLVERR and no register change; read from 0x10 → RDATA=0 with SLVERR.
